// File: rtl/migu_mem_pkg.sv
// Shared definitions for the MigU unified-SRAM arbiter: default sizes,
// the response owner encoding and the streak counter width.
package migu_mem_pkg;

    localparam int DEF_ADDR_WIDTH    = 16;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_MAX_LS_STREAK = 4;
    localparam int WORD_ADDR_W       = DEF_ADDR_WIDTH - 2;
    localparam int STREAK_W          = 4;

    // Who owns the SRAM read data returning in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_LS_RD = 2'd2,
        OWN_LS_WR = 2'd3
    } owner_e;

endpackage

// File: rtl/migu_arb_streak.sv
// Priority decision between fetch (IF) and load/store (LS) plus the LS
// streak counter that guarantees fetch a slot after MAX_LS_STREAK
// consecutive LS wins while fetch was waiting.
module migu_arb_streak
    import migu_mem_pkg::*;
#(
    parameter int MAX_LS_STREAK = DEF_MAX_LS_STREAK
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_valid_i,
    input  logic ls_valid_i,
    output logic grant_if_o,
    output logic grant_ls_o
);

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_LS_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                if_turn;

    // Grants and next streak; reset masks all grants so SRAM outputs drop at once.
    always_comb begin
        if_turn    = (streak_q == MAX_S);
        grant_if_o = !rst_i && if_valid_i && (!ls_valid_i || if_turn);
        grant_ls_o = !rst_i && ls_valid_i && !grant_if_o;
        streak_d   = streak_q;
        if (!if_valid_i || grant_if_o) begin
            streak_d = '0;
        end else if (grant_ls_o && !if_turn) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Streak register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/migu_mem_arbiter.sv
// Arbiter sharing the single-port unified SRAM between instruction fetch
// (read-only) and the load/store unit. One grant per cycle; read data
// returns one cycle later and is steered by the owner register.
// Optional grant/conflict statistics: define MIGU_MEM_ARB_STATS_EN.
//
// Handshake: a request transfers on valid && ready in the same cycle;
// ready goes only to the granted requester, and the requester holds its
// request fields stable while valid && !ready. Responses have no
// backpressure and arrive exactly one cycle after the grant.
module migu_mem_arbiter
    import migu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MAX_LS_STREAK = DEF_MAX_LS_STREAK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    output logic                    if_req_ready,
    input  logic [ADDR_WIDTH-3:0]   if_req_addr,
    output logic                    if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   if_rsp_data,
    input  logic                    ls_req_valid,
    output logic                    ls_req_ready,
    input  logic                    ls_req_we,
    input  logic [DATA_WIDTH/8-1:0] ls_req_be,
    input  logic [ADDR_WIDTH-3:0]   ls_req_addr,
    input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
    output logic                    ls_rsp_valid,
    output logic [DATA_WIDTH-1:0]   ls_rsp_data,
    output logic                    sram_en,
    output logic                    sram_we,
    output logic [DATA_WIDTH/8-1:0] sram_be,
    output logic [ADDR_WIDTH-3:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
`ifdef MIGU_MEM_ARB_STATS_EN
    ,
    output logic [31:0]             stat_if_grants,
    output logic [31:0]             stat_ls_grants,
    output logic [31:0]             stat_conflicts
`endif
);

    logic   grant_if, grant_ls;
    owner_e owner_q, owner_d;

    migu_arb_streak #(
        .MAX_LS_STREAK(MAX_LS_STREAK)
    ) u_streak (
        .clk_i      (clk),
        .rst_i      (rst),
        .if_valid_i (if_req_valid),
        .ls_valid_i (ls_req_valid),
        .grant_if_o (grant_if),
        .grant_ls_o (grant_ls)
    );

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    // SRAM request mux: LS fields when LS wins, read-only access for IF, zeros when idle.
    always_comb begin
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (grant_ls) begin
            sram_en    = 1'b1;
            sram_we    = ls_req_we;
            sram_be    = ls_req_be;
            sram_addr  = ls_req_addr;
            sram_wdata = ls_req_wdata;
        end else if (grant_if) begin
            sram_en    = 1'b1;
            sram_addr  = if_req_addr;
        end
    end

    // Next owner: set by this cycle's grant, otherwise falls back to NONE.
    always_comb begin
        owner_d = OWN_NONE;
        if (grant_if) begin
            owner_d = OWN_IF;
        end else if (grant_ls) begin
            owner_d = ls_req_we ? OWN_LS_WR : OWN_LS_RD;
        end
    end

    // Owner register; reset drops any response still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Response steering; data is forced to zero whenever its valid is low.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = '0;
        case (owner_q)
            OWN_IF: begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = sram_rdata;
            end
            OWN_LS_RD: begin
                ls_rsp_valid = 1'b1;
                ls_rsp_data  = sram_rdata;
            end
            OWN_LS_WR: begin
                ls_rsp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef MIGU_MEM_ARB_STATS_EN
    logic [31:0] stat_if_q, stat_ls_q, stat_conf_q;

    // Free-running grant and conflict counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_if_q   <= '0;
            stat_ls_q   <= '0;
            stat_conf_q <= '0;
        end else begin
            if (grant_if) begin
                stat_if_q <= stat_if_q + 32'd1;
            end
            if (grant_ls) begin
                stat_ls_q <= stat_ls_q + 32'd1;
            end
            if (if_req_valid && ls_req_valid) begin
                stat_conf_q <= stat_conf_q + 32'd1;
            end
        end
    end

    assign stat_if_grants = stat_if_q;
    assign stat_ls_grants = stat_ls_q;
    assign stat_conflicts = stat_conf_q;
`endif

endmodule

// File: tb/tb_migu_mem_arbiter.sv
// Bench for migu_mem_arbiter: behavioural SRAM, a rule-level reference
// model (grant rules, shadow memory, expected-response queues), directed
// scenarios followed by randomized traffic.
module tb_migu_mem_arbiter;

    localparam int AW  = 14;
    localparam int DW  = 32;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready, if_rsp_valid;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_rsp_data;
    logic          ls_req_valid, ls_req_ready, ls_req_we, ls_rsp_valid;
    logic [3:0]    ls_req_be;
    logic [AW-1:0] ls_req_addr;
    logic [DW-1:0] ls_req_wdata, ls_rsp_data;
    logic          sram_en, sram_we;
    logic [3:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
`ifdef MIGU_MEM_ARB_STATS_EN
    logic [31:0]   stat_if_grants, stat_ls_grants, stat_conflicts;
`endif

    migu_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_req_we    (ls_req_we),
        .ls_req_be    (ls_req_be),
        .ls_req_addr  (ls_req_addr),
        .ls_req_wdata (ls_req_wdata),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_data  (ls_rsp_data),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_be      (sram_be),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
`ifdef MIGU_MEM_ARB_STATS_EN
        ,
        .stat_if_grants (stat_if_grants),
        .stat_ls_grants (stat_ls_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural SRAM ----------------
    bit [DW-1:0] sram_mem [0:16383];
    initial sram_rdata = '0;
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr];
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- reference model ----------------
    bit [DW-1:0]   ref_mem [0:16383];
    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_ls_q[$];
    int            m_streak;
    logic          m_gif, m_gls;
    int unsigned   m_st_if, m_st_ls, m_st_conf;
    logic          obs_gif[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sram_mem[a] = d;
        ref_mem[a]  = d;
    endtask

    task automatic check_rsp();
        logic [DW-1:0] e;
        if (exp_if_q.size() > 0) begin
            e = exp_if_q.pop_front();
            check("if_rsp_valid", 32'(if_rsp_valid), 32'd1);
            check("if_rsp_data", if_rsp_data, e);
        end else begin
            check("if_rsp_valid", 32'(if_rsp_valid), 32'd0);
            check("if_rsp_data", if_rsp_data, 32'd0);
        end
        if (exp_ls_q.size() > 0) begin
            e = exp_ls_q.pop_front();
            check("ls_rsp_valid", 32'(ls_rsp_valid), 32'd1);
            check("ls_rsp_data", ls_rsp_data, e);
        end else begin
            check("ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);
            check("ls_rsp_data", ls_rsp_data, 32'd0);
        end
    endtask

    // One clock cycle of traffic: drive, check against the rules, advance the model.
    task automatic step(input logic ifv, input logic [AW-1:0] ifa, input logic lsv,
                        input logic we, input logic [3:0] be, input logic [AW-1:0] la,
                        input logic [DW-1:0] wd);
        logic [DW-1:0] e_wd;
        @(negedge clk);
        if_req_valid = ifv;
        if_req_addr  = ifa;
        ls_req_valid = lsv;
        ls_req_we    = we;
        ls_req_be    = be;
        ls_req_addr  = la;
        ls_req_wdata = wd;
        #1;
        // LS wins unless IF has waited through MAX LS grants, or LS is absent.
        m_gif = ifv && (!lsv || m_streak == MAX);
        m_gls = lsv && !m_gif;
        obs_gif.push_back(if_req_ready);
        check("if_req_ready", 32'(if_req_ready), 32'(m_gif));
        check("ls_req_ready", 32'(ls_req_ready), 32'(m_gls));
        check("sram_en", 32'(sram_en), 32'(m_gif || m_gls));
        check("sram_we", 32'(sram_we), 32'(m_gls && we));
        check("sram_be", 32'(sram_be), m_gls ? 32'(be) : 32'd0);
        check("sram_addr", 32'(sram_addr), m_gls ? 32'(la) : (m_gif ? 32'(ifa) : 32'd0));
        e_wd = m_gls ? wd : 32'd0;
        check("sram_wdata", sram_wdata, e_wd);
        check_rsp();
`ifdef MIGU_MEM_ARB_STATS_EN
        check("stat_if", stat_if_grants, m_st_if);
        check("stat_ls", stat_ls_grants, m_st_ls);
        check("stat_conf", stat_conflicts, m_st_conf);
`endif
        if (m_gif) exp_if_q.push_back(ref_mem[ifa]);
        if (m_gls) begin
            if (we) begin
                exp_ls_q.push_back(32'd0);
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[la][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                exp_ls_q.push_back(ref_mem[la]);
            end
        end
        if (!ifv || m_gif) m_streak = 0;
        else if (m_gls && m_streak < MAX) m_streak++;
        if (m_gif) m_st_if++;
        if (m_gls) m_st_ls++;
        if (ifv && lsv) m_st_conf++;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sram_en"}, 32'(sram_en), 32'd0);
        check({tag, "_sram_we"}, 32'(sram_we), 32'd0);
        check({tag, "_sram_be"}, 32'(sram_be), 32'd0);
        check({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_sram_wdata"}, sram_wdata, 32'd0);
        check({tag, "_if_ready"}, 32'(if_req_ready), 32'd0);
        check({tag, "_ls_ready"}, 32'(ls_req_ready), 32'd0);
        check({tag, "_if_rsp_valid"}, 32'(if_rsp_valid), 32'd0);
        check({tag, "_ls_rsp_valid"}, 32'(ls_rsp_valid), 32'd0);
        check({tag, "_ls_rsp_data"}, ls_rsp_data, 32'd0);
    endtask

    bit exp_seq10 [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    bit exp_seq5  [5]  = '{0, 0, 0, 0, 1};

    initial begin
        logic          p_if_v, p_ls_v, p_we;
        logic [AW-1:0] p_if_a, p_ls_a;
        logic [3:0]    p_be;
        logic [DW-1:0] p_wd;
`ifdef MIGU_MEM_ARB_STATS_EN
        int unsigned s_if0, s_ls0, s_cf0;
`endif
        // ---------- clock/reset ----------
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        ls_req_valid = 1'b0; ls_req_we = 1'b0; ls_req_be = '0;
        ls_req_addr = '0; ls_req_wdata = '0;
        m_streak = 0; m_st_if = 0; m_st_ls = 0; m_st_conf = 0;
        for (int i = 0; i < 64; i++) preload(AW'(i), $urandom());
        preload(14'h0010, 32'h0000_0013);
        preload(14'h0020, 32'h0000_0000);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ---------- IF only ----------
        step(1'b1, 14'h0010, 1'b0, 1'b0, 4'h0, '0, 32'h0);
        check("tp_if_ready", 32'(if_req_ready), 32'd1);
        idle();
        check("tp_if_rsp_data", if_rsp_data, 32'h0000_0013);
        check("tp_if_ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);

        // ---------- LS partial write then read ----------
        step(1'b0, '0, 1'b1, 1'b1, 4'b0011, 14'h0020, 32'hAABB_CCDD);
        step(1'b0, '0, 1'b1, 1'b0, 4'b0000, 14'h0020, 32'h0);
        check("tp_wr_ack_data", ls_rsp_data, 32'h0);
        idle();
        check("tp_rd_data", ls_rsp_data, 32'h0000_CCDD);

        // ---------- 10-cycle conflict ----------
        idle();
`ifdef MIGU_MEM_ARB_STATS_EN
        s_if0 = m_st_if; s_ls0 = m_st_ls; s_cf0 = m_st_conf;
`endif
        obs_gif.delete();
        for (int i = 0; i < 10; i++)
            step(1'b1, AW'(i), 1'b1, 1'b0, 4'hf, AW'(32 + i), 32'h0);
        for (int i = 0; i < 10; i++)
            check("conflict_seq_if_grant", 32'(obs_gif[i]), 32'(exp_seq10[i]));
        idle();
`ifdef MIGU_MEM_ARB_STATS_EN
        check("stat_ls_delta", stat_ls_grants - s_ls0, 32'd8);
        check("stat_if_delta", stat_if_grants - s_if0, 32'd2);
        check("stat_conf_delta", stat_conflicts - s_cf0, 32'd10);
`endif

        // ---------- back-to-back IF ----------
        for (int i = 0; i < 3; i++) step(1'b1, AW'(i), 1'b0, 1'b0, 4'h0, '0, 32'h0);
        check("b2b_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        idle();
        check("b2b_last_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        idle();

        // ---------- reset with LS read in flight ----------
        for (int i = 0; i < 3; i++) step(1'b1, 14'h0001, 1'b1, 1'b0, 4'hf, 14'h0005, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
`ifdef MIGU_MEM_ARB_STATS_EN
        check("rst_stat_if", stat_if_grants, 32'd0);
        check("rst_stat_conf", stat_conflicts, 32'd0);
`endif
        exp_if_q.delete();
        exp_ls_q.delete();
        m_streak = 0; m_st_if = 0; m_st_ls = 0; m_st_conf = 0;
        @(negedge clk);
        rst = 1'b0;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        obs_gif.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 14'h0002, 1'b1, 1'b0, 4'hf, 14'h0006, 32'h0);
        for (int i = 0; i < 5; i++)
            check("post_rst_seq_if_grant", 32'(obs_gif[i]), 32'(exp_seq5[i]));
        idle();

        // ---------- randomized traffic ----------
        p_if_v = 1'b0; p_ls_v = 1'b0; p_we = 1'b0;
        p_if_a = '0; p_ls_a = '0; p_be = '0; p_wd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!p_if_v) begin
                p_if_v = ($urandom_range(0, 99) < 60);
                p_if_a = AW'($urandom_range(0, 63));
            end
            if (!p_ls_v) begin
                p_ls_v = ($urandom_range(0, 99) < 75);
                p_we   = $urandom_range(0, 1) == 1;
                p_be   = 4'($urandom_range(0, 15));
                p_ls_a = AW'($urandom_range(0, 63));
                p_wd   = $urandom();
            end
            step(p_if_v, p_if_a, p_ls_v, p_we, p_be, p_ls_a, p_wd);
            if (m_gif) p_if_v = 1'b0;
            if (m_gls) p_ls_v = 1'b0;
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/migu_mem_arbiter.md
Name: migu_mem_arbiter

Overview:
- Shares the single-port unified SRAM of the MigU core between two requesters: instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Sits between the MigUCore pipeline front/back ends and the SRAM instance that the TB preloads via its load task.
- Grants at most one access per cycle and routes the 1-cycle-latency read data back to the owner.
- A streak counter prevents fetch starvation.

Parameters:
- ADDR_WIDTH, 16, byte address width; all ports carry word addresses of ADDR_WIDTH-2 bits.
- DATA_WIDTH, 32, SRAM word width; byte enables are DATA_WIDTH/8 bits.
- MAX_LS_STREAK, 4, maximum consecutive LS grants while IF is waiting; range 1..15.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_WIDTH-2  fetch word address
- if_rsp_valid  out  1  fetch data valid, no backpressure
- if_rsp_data  out  DATA_WIDTH  fetch data
- ls_req_valid  in  1  LS request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_req_we  in  1  1 = write
- ls_req_be  in  DATA_WIDTH/8  write byte enables
- ls_req_addr  in  ADDR_WIDTH-2  LS word address
- ls_req_wdata  in  DATA_WIDTH  write data
- ls_rsp_valid  out  1  LS read data valid or write ack, no backpressure
- ls_rsp_data  out  DATA_WIDTH  LS read data; 0 for a write ack
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_be  out  DATA_WIDTH/8  SRAM byte enables
- sram_addr  out  ADDR_WIDTH-2  SRAM word address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid 1 cycle after sram_en

Behaviour:
- Grant logic is combinational from the valids and the registered state. A request is accepted on valid && ready.
- Priority: LS wins by default. IF wins when IF is valid and streak == MAX_LS_STREAK.
- ready is asserted only to the granted requester. The requester must hold addr/data stable while valid && !ready.
- SRAM outputs:
  - sram_en = any grant.
  - sram_we/sram_be/sram_wdata come from LS when LS is granted.
  - IF grants drive sram_we=0 and sram_be=0.
  - When idle, all SRAM outputs are 0.
- Owner pipeline register: values NONE, IF, LS_RD, LS_WR. It is set on the grant cycle and cleared the following cycle unless a new grant is made.
- Response, exactly 1 cycle after the grant:
  - owner IF: if_rsp_valid=1, if_rsp_data=sram_rdata.
  - owner LS_RD: ls_rsp_valid=1, ls_rsp_data=sram_rdata.
  - owner LS_WR: ls_rsp_valid=1, ls_rsp_data=0.
  - Response data is 0 whenever the matching rsp_valid is 0.
- Back-to-back grants are allowed every cycle. Throughput is 1 access per cycle.
- Streak counter (4 bits):
  - increments on an LS grant while IF is valid and not granted; saturates at MAX_LS_STREAK;
  - clears on any IF grant, or on any cycle where IF is not valid.
- Simultaneous request with streak < MAX: LS granted, IF stalls.
- Only one requester valid: that requester is granted immediately, regardless of streak.
- Reset (async, any time, including with a grant in flight): owner=NONE, streak=0. All outputs go to 0 immediately, and a pending response is dropped. The first grant is possible in the first cycle after rst deasserts.

Optional Feature:
- Macro: MIGU_MEM_ARB_STATS_EN.
- Defined: adds output ports stat_if_grants, stat_ls_grants and stat_conflicts, each 32 bits.
  - stat_if_grants and stat_ls_grants count grants per requester.
  - stat_conflicts counts cycles with both requesters valid.
  - All three wrap modulo 2^32 and reset to 0 on rst.
- Undefined: these ports and their registers do not exist, and the grant/response behaviour is identical.

Decomposition:
- Shared package migu_mem_pkg holds:
  - the enum owner_e {OWN_NONE, OWN_IF, OWN_LS_RD, OWN_LS_WR};
  - localparam WORD_ADDR_W = ADDR_WIDTH-2;
  - the default DATA_WIDTH constant.
- One sub-module: migu_arb_streak, containing the streak counter plus the priority decision, with outputs grant_if and grant_ls.
- The response mux and owner register stay in the top-level module.

Test Plan:
- IF only, addr 0x0010 with SRAM word 0x00000013 -> if_req_ready=1 the same cycle; next cycle if_rsp_valid=1, if_rsp_data=0x00000013; ls_rsp_valid=0.
- LS write to addr 0x0020, be=4'b0011, wdata=0xAABBCCDD, then LS read of 0x0020 from prior 0 -> write ack with ls_rsp_data=0; read returns 0x0000CCDD.
- IF and LS both held valid for 10 cycles, MAX_LS_STREAK=4 -> grant sequence LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Back-to-back IF reads of 0x0,0x1,0x2 -> three consecutive if_rsp_valid cycles with matching data; no bubble.
- rst asserted in the cycle after an LS read grant -> ls_rsp_valid stays 0, all SRAM outputs are 0 immediately, and streak=0 after release.
- With MIGU_MEM_ARB_STATS_EN: run the 10-cycle conflict scenario -> stat_ls_grants=8, stat_if_grants=2, stat_conflicts=10.
